// File: rtl/sid_audio_pkg.sv
// Shared defaults for the SID PWM audio output stage.
// Build option: define SID_PWM_NOISE_SHAPE_EN to carry truncated LSBs between frames.
package sid_audio_pkg;

   // Default input sample width (unsigned, offset-binary)
   localparam int IN_W_DEF  = 10;
   // Default PWM resolution; a frame is 2^PWM_W clocks
   localparam int PWM_W_DEF = 8;
   // Bits dropped when reducing a sample to a duty value
   localparam int FRAC_W    = IN_W_DEF - PWM_W_DEF;
   // Largest duty value: high for all but one clock of the frame
   localparam int DUTY_MAX  = (1 << PWM_W_DEF) - 1;

endpackage

// File: rtl/sid_pwm_quantizer.sv
// Reduces a buffered sample to a PWM duty value.
// Build option SID_PWM_NOISE_SHAPE_EN: add the previous frame's truncation error
// before truncating, saturating at full scale; otherwise plain truncation.
module sid_pwm_quantizer #(
   parameter int IN_W  = 10,
   parameter int PWM_W = 8,
   parameter int ERR_W = 2
) (
   input  logic [IN_W-1:0]  i_buf,
   input  logic [ERR_W-1:0] i_err,
   output logic [PWM_W-1:0] o_duty,
   output logic [ERR_W-1:0] o_err_next
);

   localparam int FRAC_W_Q = IN_W - PWM_W;

`ifdef SID_PWM_NOISE_SHAPE_EN
   logic [IN_W:0] w_sum;

   // Error-feedback truncation; an overflow clamps the duty and discards the error
   always_comb begin
      w_sum      = {1'b0, i_buf} + {{(IN_W + 1 - ERR_W){1'b0}}, i_err};
      o_duty     = w_sum[IN_W-1:FRAC_W_Q];
      o_err_next = w_sum[FRAC_W_Q-1:0];
      if (w_sum[IN_W]) begin
         o_duty     = '1;
         o_err_next = '0;
      end
   end
`else
   logic w_unused;

   // Plain truncation to the top PWM_W bits; error stays zero
   assign o_duty     = i_buf[IN_W-1 -: PWM_W];
   assign o_err_next = '0;
   assign w_unused   = ^{i_err, i_buf};
`endif

endmodule

// File: rtl/sid_pwm_audio_out.sv
// SID audio output stage: one-entry sample buffer feeding a free-running PWM.
// Build option SID_PWM_NOISE_SHAPE_EN (in sid_pwm_quantizer) enables noise shaping.
module sid_pwm_audio_out
   import sid_audio_pkg::*;
#(
   parameter int IN_W  = IN_W_DEF,
   parameter int PWM_W = PWM_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic [IN_W-1:0] sample_in,
   input  logic            sample_valid,
   output logic            sample_ready,
   input  logic            clr_underrun,
   output logic            pwm_out,
   output logic            frame_strobe,
   output logic            underrun
);

   localparam int Q_FRAC_W = IN_W - PWM_W;
   localparam int Q_ERR_W  = (Q_FRAC_W > 0) ? Q_FRAC_W : 1;

   logic [PWM_W-1:0]   r_cnt;
   logic [PWM_W-1:0]   r_duty;
   logic [Q_ERR_W-1:0] r_err;
   logic [IN_W-1:0]    r_buf;
   logic               r_buf_full;
   logic               r_pwm;
   logic               r_strobe;
   logic               r_underrun;

   logic               w_load;
   logic               w_accept;
   logic [PWM_W-1:0]   w_duty_next;
   logic [Q_ERR_W-1:0] w_err_next;

   // Frame boundary is the last count of the frame; buffer state is taken before this edge
   assign w_load       = ena & (r_cnt == {PWM_W{1'b1}});
   assign sample_ready = ~rst & ena & ~r_buf_full;
   assign w_accept     = sample_valid & sample_ready;

   sid_pwm_quantizer #(
      .IN_W  (IN_W),
      .PWM_W (PWM_W),
      .ERR_W (Q_ERR_W)
   ) u_quant (
      .i_buf      (r_buf),
      .i_err      (r_err),
      .o_duty     (w_duty_next),
      .o_err_next (w_err_next)
   );

   // Frame counter, registered comparator output and frame-start strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_pwm    <= 1'b0;
         r_strobe <= 1'b0;
      end else begin
         if (ena) r_cnt <= r_cnt + 1'b1;
         r_pwm    <= ena & (r_cnt < r_duty);
         r_strobe <= w_load;
      end
   end

   // Sample buffer and per-frame duty/error load; a load with an empty buffer keeps the old duty
   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf      <= '0;
         r_buf_full <= 1'b0;
         r_duty     <= '0;
         r_err      <= '0;
      end else begin
         if (w_load && r_buf_full) begin
            r_duty     <= w_duty_next;
            r_err      <= w_err_next;
            r_buf_full <= 1'b0;
         end
         // Acceptance is only possible with the buffer empty, so it never races a load
         if (w_accept) begin
            r_buf      <= sample_in;
            r_buf_full <= 1'b1;
         end
      end
   end

   // Sticky underrun flag; a set in the same cycle as a clear takes priority
   always_ff @(posedge clk) begin
      if (rst) begin
         r_underrun <= 1'b0;
      end else begin
         if (clr_underrun) r_underrun <= 1'b0;
         if (w_load && !r_buf_full) r_underrun <= 1'b1;
      end
   end

   assign pwm_out      = r_pwm;
   assign frame_strobe = r_strobe;
   assign underrun     = r_underrun;

endmodule
